// File: rtl/ipsxe_floating_point_stim_ctrl.sv
// Stimulus controller for the floating-point core example design.
// Walks the operand ROMs through NUM_VEC addresses, hands each operand pair
// to the core over a valid/ready handshake, then waits for the result. The
// wait is bounded by a timeout. Results that arrive outside the wait window
// are flagged as spurious.
`timescale 1ns/1ps

module ipsxe_floating_point_stim_ctrl #(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23,
  parameter int NUM_VEC   = 4,
  parameter int TIMEOUT   = 256
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic [3:0]                     rd_addr_a,
  output logic [3:0]                     rd_addr_b,
  input  logic [EXP_WIDTH+MAN_WIDTH:0]   rom_dout_a,
  input  logic [EXP_WIDTH+MAN_WIDTH:0]   rom_dout_b,
  output logic                           a_tvalid,
  output logic [EXP_WIDTH+MAN_WIDTH:0]   a_tdata,
  output logic                           b_tvalid,
  output logic [EXP_WIDTH+MAN_WIDTH:0]   b_tdata,
  input  logic                           ab_tready,
  input  logic                           res_tvalid,
  input  logic [EXP_WIDTH+MAN_WIDTH:0]   res_tdata,
  output logic                           busy,
  output logic                           done,
  output logic                           err_timeout,
  output logic                           err_spurious,
  output logic [4:0]                     res_cnt,
  output logic [EXP_WIDTH+MAN_WIDTH:0]   last_result
);

  localparam int W = 1 + EXP_WIDTH + MAN_WIDTH;

  // Index of the final vector and the last timer value before giving up.
  localparam logic [3:0]  LAST_IDX = 4'(NUM_VEC - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_DRIVE,
    S_WAIT_RES,
    S_DONE
  } state_e;

  state_e         state_q;
  logic [3:0]     vec_idx_q;
  logic [15:0]    timer_q;
  logic           a_tvalid_q;
  logic [W-1:0]   a_tdata_q;
  logic [W-1:0]   b_tdata_q;
  logic           busy_q;
  logic           done_q;
  logic           err_timeout_q;
  logic           err_spurious_q;
  logic [4:0]     res_cnt_q;
  logic [W-1:0]   last_result_q;

  // Next-state helpers for the handshake and result window.
  logic accept_d;
  logic timer_expired_d;
  logic spurious_d;

  // Decode the events that steer the sequencer this cycle.
  always_comb begin
    // NOTE: every signal gets a value before any condition so no latch can be inferred.
    accept_d        = 1'b0;
    timer_expired_d = 1'b0;
    spurious_d      = 1'b0;
    if (state_q == S_DRIVE) begin
      accept_d = a_tvalid_q && ab_tready;
    end
    if (state_q == S_WAIT_RES) begin
      timer_expired_d = (timer_q == TMO_LAST);
    end else begin
      spurious_d = res_tvalid;
    end
  end

  // Sequencer: walks the vectors, drives the handshake, and collects the results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the datapath registers are reset as well, so tdata and last_result read 0 and no stale run state survives an abort.
      state_q        <= S_IDLE;
      vec_idx_q      <= '0;
      timer_q        <= '0;
      a_tvalid_q     <= 1'b0;
      a_tdata_q      <= '0;
      b_tdata_q      <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_spurious_q <= 1'b0;
      res_cnt_q      <= '0;
      last_result_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update in step with the others on this edge.
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q        <= S_FETCH;
            vec_idx_q      <= '0;
            res_cnt_q      <= '0;
            err_timeout_q  <= 1'b0;
            err_spurious_q <= 1'b0;
            busy_q         <= 1'b1;
            done_q         <= 1'b0;
          end
        end

        // The address is stable for this whole cycle, and the ROM registers it on the closing edge.
        S_FETCH: begin
          state_q <= S_LOAD;
        end

        S_LOAD: begin
          a_tdata_q  <= rom_dout_a;
          b_tdata_q  <= rom_dout_b;
          a_tvalid_q <= 1'b1;
          state_q    <= S_DRIVE;
        end

        // Hold valid and data for as long as the core applies backpressure.
        S_DRIVE: begin
          if (accept_d) begin
            a_tvalid_q <= 1'b0;
            timer_q    <= '0;
            state_q    <= S_WAIT_RES;
          end
        end

        // A result that arrives on the final timer cycle still counts.
        S_WAIT_RES: begin
          if (res_tvalid) begin
            last_result_q <= res_tdata;
            res_cnt_q     <= res_cnt_q + 5'd1;
            if (vec_idx_q == LAST_IDX) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              vec_idx_q <= vec_idx_q + 4'd1;
              state_q   <= S_FETCH;
            end
          end else if (timer_expired_d) begin
            err_timeout_q <= 1'b1;
            state_q       <= S_DONE;
            busy_q        <= 1'b0;
            done_q        <= 1'b1;
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end

        default: begin
          state_q    <= S_IDLE;
          a_tvalid_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase

      // Placed after the case so a stray result still gets flagged when a restart clears the flags on the same cycle.
      if (spurious_d) begin
        err_spurious_q <= 1'b1;
      end
    end
  end

  assign rd_addr_a    = vec_idx_q;
  assign rd_addr_b    = vec_idx_q;
  assign a_tvalid     = a_tvalid_q;
  assign b_tvalid     = a_tvalid_q;
  assign a_tdata      = a_tdata_q;
  assign b_tdata      = b_tdata_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err_timeout  = err_timeout_q;
  assign err_spurious = err_spurious_q;
  assign res_cnt      = res_cnt_q;
  assign last_result  = last_result_q;

  // The vector index never runs past the final ROM entry.
  a_idx_in_range: assert property (@(posedge clk) disable iff (rst)
    vec_idx_q <= LAST_IDX);

  // An offered operand pair stays put until the core takes it.
  a_hold_under_backpressure: assert property (@(posedge clk) disable iff (rst)
    (a_tvalid_q && !ab_tready) |=> (a_tvalid_q && $stable(a_tdata_q) && $stable(b_tdata_q)));

  // busy and done are never high together.
  a_busy_done_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(busy_q && done_q));

endmodule

// File: tb/tb_ipsxe_floating_point_stim_ctrl.sv
// Bench for ipsxe_floating_point_stim_ctrl. A table of run configurations
// is checked against hand-derived cycle counts. A behavioural core/ROM model
// drives the DUT, and a transaction scoreboard checks every accepted pair.
// Randomized runs and the reset/abort sequences are written out by hand.
`timescale 1ns/1ps

module tb_ipsxe_floating_point_stim_ctrl;

  localparam int NV  = 4;
  localparam int TMO = 16;
  localparam int W   = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   rd_addr_a, rd_addr_b;
  logic [W-1:0] rom_dout_a, rom_dout_b;
  logic         a_tvalid, b_tvalid;
  logic [W-1:0] a_tdata, b_tdata;
  logic         ab_tready  = 1'b0;
  logic         res_tvalid = 1'b0;
  logic [W-1:0] res_tdata  = '0;
  logic         busy, done, err_timeout, err_spurious;
  logic [4:0]   res_cnt;
  logic [W-1:0] last_result;

  ipsxe_floating_point_stim_ctrl #(
    .EXP_WIDTH(8), .MAN_WIDTH(23), .NUM_VEC(NV), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rom_dout_a(rom_dout_a), .rom_dout_b(rom_dout_b),
    .a_tvalid(a_tvalid), .a_tdata(a_tdata),
    .b_tvalid(b_tvalid), .b_tdata(b_tdata),
    .ab_tready(ab_tready),
    .res_tvalid(res_tvalid), .res_tdata(res_tdata),
    .busy(busy), .done(done),
    .err_timeout(err_timeout), .err_spurious(err_spurious),
    .res_cnt(res_cnt), .last_result(last_result)
  );

  always #5 clk = ~clk;

  wire any_out = |{rd_addr_a, rd_addr_b, a_tvalid, a_tdata, b_tvalid, b_tdata,
                   busy, done, err_timeout, err_spurious, res_cnt, last_result};

  // Operand ROMs with a registered one-cycle read port.
  logic [W-1:0] rom_a [16];
  logic [W-1:0] rom_b [16];
  always @(posedge clk) begin
    rom_dout_a <= rom_a[rd_addr_a];
    rom_dout_b <= rom_b[rd_addr_b];
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Knobs shared between the sequence thread and the core model.
  bit rand_mode = 1'b0;
  int tbl_stall = 0;
  int tbl_delay = 1;
  bit spur_knob = 1'b0;
  bit spur_done = 1'b0;
  int acc_in_run = 0;

  // Core model state.
  int           pend = 0;
  int           cur_stall = 0;
  int           wait_ctr = 0;
  logic [W-1:0] pend_data = '0;
  logic [W-1:0] prev_a = '0, prev_b = '0;
  bit           prev_hold = 1'b0;
  bit           prev_tv = 1'b0;

  // Core model and scoreboard. Runs on the falling edge, so everything it
  // drives is stable at the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      pend       = 0;
      res_tvalid = 1'b0;
      ab_tready  = 1'b0;
      prev_hold  = 1'b0;
      prev_tv    = 1'b0;
      wait_ctr   = 0;
    end else begin
      if (prev_hold) begin
        check("bp_tvalid_held", a_tvalid, 1);
        check("bp_a_tdata_held", a_tdata, prev_a);
        check("bp_b_tdata_held", b_tdata, prev_b);
      end

      res_tvalid = 1'b0;
      res_tdata  = $urandom;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          res_tvalid = 1'b1;
          res_tdata  = pend_data;
        end
      end
      if (spur_knob && !spur_done && a_tvalid && acc_in_run == 1) begin
        res_tvalid = 1'b1;
        res_tdata  = 32'hDEADBEEF;
        spur_done  = 1'b1;
      end

      if (a_tvalid && !prev_tv) begin
        cur_stall = rand_mode ? int'($urandom_range(0, 4)) : tbl_stall;
        wait_ctr  = 0;
      end
      ab_tready = a_tvalid ? (wait_ctr >= cur_stall) : 1'($urandom_range(0, 1));
      if (a_tvalid) wait_ctr++;

      if (a_tvalid && ab_tready) begin
        check("acc_index_in_range", acc_in_run < NV, 1);
        check("acc_rd_addr_a", rd_addr_a, acc_in_run);
        check("acc_rd_addr_b", rd_addr_b, acc_in_run);
        check("acc_b_tvalid", b_tvalid, 1);
        if (acc_in_run < 16) begin
          check("acc_a_tdata", a_tdata, rom_a[acc_in_run]);
          check("acc_b_tdata", b_tdata, rom_b[acc_in_run]);
        end
        pend      = rand_mode ? int'($urandom_range(1, TMO - 1)) : tbl_delay;
        pend_data = a_tdata + b_tdata;
        acc_in_run++;
      end

      prev_hold = a_tvalid && !ab_tready;
      prev_a    = a_tdata;
      prev_b    = b_tdata;
      prev_tv   = a_tvalid;
    end
  end

  typedef struct {
    int stall;       // ready held low this many DRIVE cycles per vector
    int delay;       // result this many cycles after accept; 0 = never
    bit spur;        // inject one stray result during vector 1 DRIVE
    int exp_cycles;  // edges from the start edge to entering DONE; -1 = skip
    int exp_cnt;
    int exp_acc;
    bit exp_tmo;
    bit exp_spur;    // err_spurious 20 cycles after DONE
  } run_t;

  // One complete run from start to DONE, checked against the expectations in r.
  task automatic do_run(input run_t r, input logic [W-1:0] exp_last_v);
    int n;
    logic [4:0] cnt_at_done;
    tbl_stall = r.stall;
    tbl_delay = r.delay;
    spur_knob = r.spur;
    @(negedge clk);
    acc_in_run = 0;
    spur_done  = 1'b0;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    check("start_busy", busy, 1);
    check("start_done_clear", done, 0);
    check("start_flags_cleared", {err_timeout, err_spurious}, 0);
    check("start_res_cnt_clear", res_cnt, 0);
    check("start_addr_zero", rd_addr_a, 0);
    while (!done && n < 1000) begin
      @(negedge clk);
      n++;
      if (n == 2) check("tvalid_low_after_e1", a_tvalid, 0);
      if (n == 3) check("tvalid_high_after_e2", a_tvalid, 1);
      start = (n == 5);
    end
    start = 1'b0;
    check("run_reached_done", done, 1);
    if (r.exp_cycles >= 0) check("run_cycles", n - 1, r.exp_cycles);
    check("done_res_cnt", res_cnt, r.exp_cnt);
    check("done_err_timeout", err_timeout, r.exp_tmo);
    check("done_busy_low", busy, 0);
    check("done_last_result", last_result, exp_last_v);
    check("done_accept_count", acc_in_run, r.exp_acc);
    cnt_at_done = res_cnt;
    repeat (20) @(negedge clk);
    check("post_err_spurious", err_spurious, r.exp_spur);
    check("post_done_held", done, 1);
    check("post_res_cnt_held", res_cnt, cnt_at_done);
    check("post_last_result_held", last_result, exp_last_v);
  endtask

  run_t         tbl [7];
  run_t         rr;
  logic [W-1:0] exp_last;
  bit           found;

  initial begin
    // Zero-wait vectors take 3 + stall + delay cycles each. A timeout takes
    // 3 + stall + TMO cycles on the first vector.
    tbl[0] = '{stall: 0, delay: 3,  spur: 0, exp_cycles: 24, exp_cnt: 4, exp_acc: 4, exp_tmo: 0, exp_spur: 0};
    tbl[1] = '{stall: 5, delay: 1,  spur: 0, exp_cycles: 36, exp_cnt: 4, exp_acc: 4, exp_tmo: 0, exp_spur: 0};
    tbl[2] = '{stall: 0, delay: 1,  spur: 0, exp_cycles: 16, exp_cnt: 4, exp_acc: 4, exp_tmo: 0, exp_spur: 0};
    tbl[3] = '{stall: 0, delay: 16, spur: 0, exp_cycles: 76, exp_cnt: 4, exp_acc: 4, exp_tmo: 0, exp_spur: 0};
    tbl[4] = '{stall: 0, delay: 0,  spur: 0, exp_cycles: 19, exp_cnt: 0, exp_acc: 1, exp_tmo: 1, exp_spur: 0};
    tbl[5] = '{stall: 0, delay: 17, spur: 0, exp_cycles: 19, exp_cnt: 0, exp_acc: 1, exp_tmo: 1, exp_spur: 1};
    tbl[6] = '{stall: 2, delay: 2,  spur: 1, exp_cycles: 28, exp_cnt: 4, exp_acc: 4, exp_tmo: 0, exp_spur: 1};

    for (int i = 0; i < 16; i++) begin
      rom_a[i] = 32'h3F800000 + 32'(i) * 32'h00100000;
      rom_b[i] = 32'h01010101 * 32'(i);
    end
    rom_b[0] = 32'h41000000;
    rom_b[1] = 32'h7F800000;
    rom_b[2] = 32'h7FC00000;
    rom_b[3] = 32'h00000000;

    rst   = 1'b1;
    start = 1'b0;
    #12;
    check("por_outputs_zero", any_out, 0);
    check("por_busy", busy, 0);
    check("por_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs_zero", any_out, 0);

    exp_last = '0;
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].exp_cnt == NV) exp_last = rom_a[NV-1] + rom_b[NV-1];
      do_run(tbl[i], exp_last);
    end

    // Abort during the DRIVE of vector 2, then restart from address 0.
    tbl_stall = 5;
    tbl_delay = 1;
    spur_knob = 1'b0;
    @(negedge clk);
    acc_in_run = 0;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      if (a_tvalid && rd_addr_a == 4'd2) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_reached_vec2_drive", found, 1);
    #2;
    rst = 1'b1;
    #1;
    check("abort_outputs_zero", any_out, 0);
    check("abort_tvalid_low", a_tvalid, 0);
    check("abort_busy_low", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_last = rom_a[NV-1] + rom_b[NV-1];
    do_run(tbl[2], exp_last);

    // Randomized operands, stalls and result latencies.
    rand_mode = 1'b1;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) begin
        rom_a[i] = $urandom;
        rom_b[i] = $urandom;
      end
      rr = '{stall: 0, delay: 1, spur: 0, exp_cycles: -1, exp_cnt: NV, exp_acc: NV, exp_tmo: 0, exp_spur: 0};
      exp_last = rom_a[NV-1] + rom_b[NV-1];
      do_run(rr, exp_last);
    end
    rand_mode = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL global_watchdog: got time %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
